io_display_unit: RTL

Memory-mapped-free I/O stage for the single-cycle MIPS core, downstream of the processor datapath. It consumes the register value the core emits on an output instruction, converts it to signed decimal and drives the eight active-low seven-segment displays. It also serves input instructions: it debounces the insert key and latches the switch bank into `user_input` for the register write-back path.

---
 rtl/io_display_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/io_display_unit.sv
// io_display_unit: signed decimal driver for eight active-low seven-segment
// displays plus a debounced key/switch input port for the MIPS core.
module io_display_unit #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        halt,
   input  logic [31:0] out_data,
   input  logic        output_flag,
   input  logic        input_flag,
   input  logic        insert,
   input  logic [14:0] SW,
   output logic [31:0] user_input,
   output logic        input_done,
   output logic        waiting_input,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam int         CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   state_t      state;
   logic        pending_full;
   logic [31:0] pending_data;
   logic [51:0] dd_reg;
   logic [51:0] dd_adj;
   logic [51:0] dd_next;
   logic [4:0]  bit_cnt;
   logic        neg_reg;
   logic        ovf_reg;
   logic [6:0]  hex_reg  [8];
   logic [6:0]  seg_next [8];
   logic        leading;
   logic [3:0]  digit;

   logic        req;
   logic        use_pending;
   logic        do_start;
   logic [31:0] start_data;
   logic        start_neg;
   logic [31:0] start_mag;
   logic        start_ovf;

   logic        insert_meta;
   logic        insert_sync;
   logic [14:0] sw_meta;
   logic [14:0] sw_sync;
   logic        key_pressed;
   logic [CW-1:0] deb_cnt;
   logic        accepted;
   logic        key_raw_pressed;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // The slot is consumed when LOAD finishes, so a conversion start takes
   // the slot value there and the live bus otherwise.
   assign req         = output_flag & ~halt;
   assign use_pending = (state == LOAD) & pending_full;
   assign do_start    = ((state == IDLE) & req) | ((state == LOAD) & (pending_full | req));
   assign start_data  = use_pending ? pending_data : out_data;
   assign start_neg   = start_data[31];
   assign start_mag   = start_neg ? (~start_data + 32'd1) : start_data;
   assign start_ovf   = (start_mag > 32'd9999999);

   // One double-dabble step: correct every BCD digit of 5 or more, then shift.
   always_comb begin
      dd_adj = dd_reg;
      for (int i = 0; i < 7; i++) begin
         if (dd_adj[24 + 4*i +: 4] >= 4'd5)
            dd_adj[24 + 4*i +: 4] = dd_adj[24 + 4*i +: 4] + 4'd3;
      end
      dd_next = dd_adj << 1;
   end

   // Segment image for the finished conversion, blanking leading zeros above HEX0.
   always_comb begin
      seg_next = '{default: SEG_BLANK};
      leading  = 1'b1;
      digit    = 4'd0;
      for (int i = 6; i >= 1; i--) begin
         digit = dd_reg[24 + 4*i +: 4];
         if (leading && (digit == 4'd0)) begin
            seg_next[i] = SEG_BLANK;
         end else begin
            leading     = 1'b0;
            seg_next[i] = seg_of(digit);
         end
      end
      seg_next[0] = seg_of(dd_reg[27:24]);
      seg_next[7] = neg_reg ? SEG_DASH : SEG_BLANK;
      if (ovf_reg)
         seg_next = '{default: SEG_DASH};
   end

   // Display FSM: capture, convert one bit per cycle, load the displays, with a one-deep latest-wins slot.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         pending_full <= 1'b0;
         pending_data <= 32'd0;
         dd_reg       <= 52'd0;
         bit_cnt      <= 5'd0;
         neg_reg      <= 1'b0;
         ovf_reg      <= 1'b0;
         hex_reg[0]   <= SEG_ZERO;
         for (int i = 1; i < 8; i++)
            hex_reg[i] <= SEG_BLANK;
      end else begin
         if (state == LOAD) begin
            for (int i = 0; i < 8; i++)
               hex_reg[i] <= seg_next[i];
         end
         if (req && ((state == CONVERT) || use_pending)) begin
            pending_data <= out_data;
            pending_full <= 1'b1;
         end else if (use_pending) begin
            pending_full <= 1'b0;
         end
         if (do_start) begin
            neg_reg <= start_neg;
            ovf_reg <= start_ovf;
            dd_reg  <= {28'd0, start_mag[23:0]};
            bit_cnt <= 5'd0;
            busy    <= 1'b1;
            state   <= start_ovf ? LOAD : CONVERT;
         end else begin
            case (state)
               CONVERT: begin
                  dd_reg  <= dd_next;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd23)
                     state <= LOAD;
               end
               LOAD: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign HEX0 = hex_reg[0];
   assign HEX1 = hex_reg[1];
   assign HEX2 = hex_reg[2];
   assign HEX3 = hex_reg[3];
   assign HEX4 = hex_reg[4];
   assign HEX5 = hex_reg[5];
   assign HEX6 = hex_reg[6];
   assign HEX7 = hex_reg[7];

   assign key_raw_pressed = ~insert_sync;
   assign waiting_input   = input_flag & ~accepted;

   // Input path: synchronize key and switches, debounce the key, accept one value per press.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         insert_meta <= 1'b1;
         insert_sync <= 1'b1;
         sw_meta     <= 15'd0;
         sw_sync     <= 15'd0;
         key_pressed <= 1'b0;
         deb_cnt     <= '0;
         accepted    <= 1'b0;
         input_done  <= 1'b0;
         user_input  <= 32'd0;
      end else begin
         insert_meta <= insert;
         insert_sync <= insert_meta;
         sw_meta     <= SW;
         sw_sync     <= sw_meta;
         input_done  <= 1'b0;
         if (!input_flag)
            accepted <= 1'b0;
         if (key_raw_pressed != key_pressed) begin
            if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               key_pressed <= key_raw_pressed;
               deb_cnt     <= '0;
               if (key_raw_pressed && input_flag && !halt) begin
                  user_input <= {17'd0, sw_sync};
                  input_done <= 1'b1;
                  accepted   <= 1'b1;
               end
            end else begin
               deb_cnt <= deb_cnt + CW'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

endmodule
